// File: rtl/seq_divider64_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_DW     default divisor/quotient/remainder width (dividend is 2*DIV_DW)
//   state_e    controller state encoding
//   cnt_width  iteration counter width for a given DW
package seq_divider64_pkg;

    localparam int DIV_DW = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/seq_divider64_if.sv
// Handshake bundle for seq_divider64.
//   master: requester/consumer side (drives operands and out_ready)
//   slave : divider side (drives in_ready, results and flags)
interface seq_divider64_if
    import seq_divider64_pkg::*;
#(
    parameter int DW = DIV_DW
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     quotient;
    logic [DW-1:0]     remainder;
    logic              div0;
    logic              ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div0, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div0, ovf
    );
endinterface

// File: rtl/seq_divider64_step.sv
// One restoring-division step (combinational).
//   r_in    partial remainder, always < divisor
//   bit_in  next dividend bit shifted in
//   divisor denominator
//   r_out   updated partial remainder
//   q_bit   quotient bit produced by this step
// The trial subtraction is DW+1 bits wide; its MSB is the borrow. Because
// r_in < divisor, whenever the shifted value overflows DW bits the
// subtraction succeeds, so the restored value always fits in DW bits.
module seq_divider64_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] r_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] r_out,
    output logic          q_bit
);
    logic [DW:0] t;
    logic [DW:0] d;

    always_comb begin
        t     = {r_in, bit_in};
        d     = t - {1'b0, divisor};
        q_bit = ~d[DW];
        r_out = d[DW] ? t[DW-1:0] : d[DW-1:0];
    end
endmodule

// File: rtl/seq_divider64.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one
// quotient bit per clock, valid/ready handshakes on both sides.
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    seq_divider64_if slave modport (operands, results, div0/ovf)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | in_ready high, waiting for an operation
// S_CHECK | screen divisor==0 and quotient overflow, or seed iteration
// S_RUN   | DW restoring steps, one quotient bit per cycle
// S_DONE  | out_valid high, results held until out_ready
module seq_divider64
    import seq_divider64_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_divider64_if.slave   bus
);
    localparam int CW = cnt_width(DW);

    state_e          state_q, state_d;
    logic [DW-1:0]   r_q, r_d;      // partial remainder; dividend high half before RUN
    logic [DW-1:0]   lo_q, lo_d;    // dividend low half, shifted out MSB first
    logic [DW-1:0]   q_q, q_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;

    logic [DW-1:0]   step_r;
    logic            step_q;

    seq_divider64_step #(.DW(DW)) u_step (
        .r_in    (r_q),
        .bit_in  (lo_q[DW-1]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            lo_q    <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            lo_q    <= lo_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        lo_d    = lo_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    r_d     = bus.dividend[2*DW-1:DW];
                    lo_d    = bus.dividend[DW-1:0];
                    dvs_d   = bus.divisor;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (dvs_q == '0) begin
                    div0_d  = 1'b1;
                    q_d     = '1;
                    r_d     = lo_q;
                    state_d = S_DONE;
                end else if (r_q >= dvs_q) begin
                    ovf_d   = 1'b1;
                    q_d     = '1;
                    r_d     = '0;
                    state_d = S_DONE;
                end else begin
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                r_d   = step_r;
                lo_d  = {lo_q[DW-2:0], 1'b0};
                q_d   = {q_q[DW-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    div0_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.quotient  = q_q;
    assign bus.remainder = r_q;
    assign bus.div0      = div0_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_divider64.sv
// Scoreboard bench for seq_divider64: the driver pushes the hand-computed
// result of each operation; a monitor pops and compares when out_valid rises.
module tb_seq_divider64;
    import seq_divider64_pkg::*;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          d0;
        logic          ov;
        int            acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    seq_divider64_if #(.DW(DW)) bus ();

    seq_divider64 #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    // Monitor: compare on the first cycle of out_valid, then check the
    // outputs hold steady for as long as out_valid stays high.
    logic          seen;
    logic [DW-1:0] snap_q, snap_r;
    logic          snap_d0, snap_ov;

    initial seen = 1'b0;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                snap_q  = bus.quotient;
                snap_r  = bus.remainder;
                snap_d0 = bus.div0;
                snap_ov = bus.ovf;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(bus.quotient), 64'hx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("quotient",  64'(bus.quotient),  64'(e.q));
                    chk("remainder", 64'(bus.remainder), 64'(e.r));
                    chk("div0",      64'(bus.div0),      64'(e.d0));
                    chk("ovf",       64'(bus.ovf),       64'(e.ov));
                    chk("latency",   64'(cyc - e.acc),   64'((e.d0 || e.ov) ? 1 : DW + 1));
                end
            end else begin
                chk("hold_quotient",  64'(bus.quotient),  64'(snap_q));
                chk("hold_remainder", 64'(bus.remainder), 64'(snap_r));
                chk("hold_flags",     64'({bus.div0, bus.ovf}), 64'({snap_d0, snap_ov}));
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Presents an operation at a negedge where in_ready is high, so it is
    // accepted at the following posedge (edge number cyc+1).
    task automatic issue(input logic [63:0] dd, input logic [DW-1:0] dv,
                         input logic [DW-1:0] eq, input logic [DW-1:0] er,
                         input logic e0, input logic eo);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("issue_timeout", 64'(bus.in_ready), 64'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        e.q = eq; e.r = er; e.d0 = e0; e.ov = eo; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_quotient"},  64'(bus.quotient),  64'd0);
        chk({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
        chk({tag, "_flags"},     64'({bus.div0, bus.ovf}), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] a, b;
        int n;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        issue(64'h4000_0000_0000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        issue(64'd1000003, 32'd1000, 32'd1000, 32'd3, 1'b0, 1'b0);
        issue(64'd999, 32'd1000, 32'd0, 32'd999, 1'b0, 1'b0);
        issue(64'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
        issue(64'h5_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        issue(64'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        issue(64'h1_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        issue(64'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();

        // Backpressure, with stray in_valid pulses while busy.
        bus.out_ready = 1'b0;
        issue(64'd77777, 32'd77, 32'd1010, 32'd7, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 64'd50;
        bus.divisor  = 32'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready_low",   64'(bus.in_ready),  64'd0);
            chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
        chk("bp_stray_not_latched", 64'(exp_q.size()),  64'd0);

        // Reset during RUN, ten steps in; the pending result is discarded.
        issue(64'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

        // Multiplier check: (a*b)/b == a, remainder 0.
        for (int i = 0; i < 8; i++) begin
            a = $urandom();
            b = $urandom();
            if (b == '0) b = 32'd1;
            issue(64'(a) * 64'(b), b, a, 32'd0, 1'b0, 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
